// File: rtl/nec_ir_if.sv
// nec_ir_if: request/status bundle between an NEC IR frame requester and the transmitter.
interface nec_ir_if;
  logic       start;
  logic [7:0] address;
  logic [7:0] command;
  logic       repeat_en;
  logic       busy;
  logic       done;
  logic       ir_envelope;
  logic       ir_out;
  modport master (output start, address, command, repeat_en, input busy, done, ir_envelope, ir_out);
  modport slave  (input start, address, command, repeat_en, output busy, done, ir_envelope, ir_out);
endinterface

// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: NEC frame / repeat-code generator with optional 38 kHz carrier.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int MODULATE     = 1,
  parameter int PERIOD_UNITS = 192
) (
  input logic     clk,
  input logic     rst_n,
  nec_ir_if.slave bus
);
  localparam int UW = $clog2(UNIT_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_UNITS + 1);
  localparam int CW = $clog2(CARRIER_HALF + 1);
  localparam logic [UW-1:0] UNIT_LAST   = UW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_UNITS - 1);
  localparam logic [CW-1:0] CAR_LAST    = CW'(CARRIER_HALF - 1);
  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP, REP_MARK, REP_SPACE, REP_STOP
  } state_t;
  state_t          state_q, state_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [4:0]      seg_q, seg_d, dur;
  logic [PW-1:0]   period_q, period_d;
  logic [4:0]      bit_q, bit_d;
  logic [31:0]     data_q, data_d;
  logic [CW-1:0]   car_cnt_q, car_cnt_d;
  logic            car_q, car_d;
  logic            unit_tick, seg_end, period_end, car_enter;
  function automatic logic is_mark(state_t s);
    return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK || s == REP_MARK || s == REP_STOP;
  endfunction
  always_comb begin
    unit_tick  = unit_q == UNIT_LAST;
    dur        = (state_q == LEAD_MARK || state_q == REP_MARK) ? 5'd16 :
                 state_q == LEAD_SPACE ? 5'd8 :
                 state_q == REP_SPACE ? 5'd4 :
                 (state_q == BIT_SPACE && data_q[0]) ? 5'd3 : 5'd1;
    seg_end    = unit_tick && seg_q == dur - 5'd1;
    period_end = unit_tick && period_q == PERIOD_LAST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = bus.start ? LEAD_MARK : IDLE;
      LEAD_MARK:  state_d = seg_end ? LEAD_SPACE : LEAD_MARK;
      LEAD_SPACE: state_d = seg_end ? BIT_MARK : LEAD_SPACE;
      BIT_MARK:   state_d = seg_end ? BIT_SPACE : BIT_MARK;
      BIT_SPACE:  state_d = !seg_end ? BIT_SPACE : bit_q == 5'd31 ? STOP_MARK : BIT_MARK;
      STOP_MARK:  state_d = seg_end ? GAP : STOP_MARK;
      GAP:        state_d = !period_end ? GAP : bus.repeat_en ? REP_MARK : IDLE;
      REP_MARK:   state_d = seg_end ? REP_SPACE : REP_MARK;
      REP_SPACE:  state_d = seg_end ? REP_STOP : REP_SPACE;
      REP_STOP:   state_d = seg_end ? GAP : REP_STOP;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.busy        = state_q != IDLE;
    bus.done        = state_q == GAP && period_end && !bus.repeat_en;
    bus.ir_envelope = is_mark(state_q);
    bus.ir_out      = is_mark(state_q) && (MODULATE == 0 || car_q);
  end
  // Period counter restarts whenever a GAP ends, so LEAD_MARK and REP_MARK both begin at 0.
  always_comb begin
    unit_d    = (state_q == IDLE || unit_tick) ? '0 : unit_q + 1'b1;
    seg_d     = (state_q == IDLE || state_q == GAP || seg_end) ? '0 : unit_tick ? seg_q + 1'b1 : seg_q;
    period_d  = (state_q == IDLE || (state_q == GAP && period_end)) ? '0 :
                unit_tick ? period_q + 1'b1 : period_q;
    data_d    = (state_q == IDLE && bus.start) ? {~bus.command, bus.command, ~bus.address, bus.address} :
                (state_q == BIT_SPACE && seg_end) ? data_q >> 1 : data_q;
    bit_d     = (state_q == IDLE) ? '0 : (state_q == BIT_SPACE && seg_end) ? bit_q + 1'b1 : bit_q;
    car_enter = state_d != state_q && is_mark(state_d);
    car_cnt_d = (car_enter || car_cnt_q == CAR_LAST) ? '0 : car_cnt_q + 1'b1;
    car_d     = car_enter ? 1'b1 : car_cnt_q == CAR_LAST ? ~car_q : car_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      unit_q    <= '0;
      seg_q     <= '0;
      period_q  <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      car_cnt_q <= '0;
      car_q     <= 1'b0;
    end else begin
      unit_q    <= unit_d;
      seg_q     <= seg_d;
      period_q  <= period_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      car_cnt_q <= car_cnt_d;
      car_q     <= car_d;
    end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// tb_nec_ir_transmitter: directed checks of NEC frames, repeats, abort and carrier.
module tb_nec_ir_transmitter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  nec_ir_if b1 ();
  nec_ir_if b2 ();
  nec_ir_transmitter #(.UNIT_CYCLES(4), .CARRIER_HALF(2), .MODULATE(0), .PERIOD_UNITS(192))
    dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  nec_ir_transmitter #(.UNIT_CYCLES(8), .CARRIER_HALF(2), .MODULATE(1), .PERIOD_UNITS(192))
    dut_mod (.clk(clk), .rst_n(rst_n), .bus(b2));
  int checks = 0;
  int failures = 0;
  int u_cyc = 4;
  int pos;
  logic env_tr [2400];
  logic out_tr [2400];
  logic done_tr [2400];
  logic exp_env [2400];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic put(logic v, int units);
    for (int k = 0; k < units * u_cyc; k++) begin
      exp_env[pos] = v;
      pos++;
    end
  endtask
  task automatic pad(int base, int units);
    while (pos < base + units * u_cyc) begin
      exp_env[pos] = 1'b0;
      pos++;
    end
  endtask
  task automatic build_frame(logic [7:0] a, logic [7:0] c);
    logic [31:0] d;
    d = {~c, c, ~a, a};
    pos = 0;
    put(1'b1, 16);
    put(1'b0, 8);
    for (int i = 0; i < 32; i++) begin
      put(1'b1, 1);
      put(1'b0, d[i] ? 3 : 1);
    end
    put(1'b1, 1);
    pad(0, 192);
  endtask
  task automatic add_repeat();
    int b;
    b = pos;
    put(1'b1, 16);
    put(1'b0, 4);
    put(1'b1, 1);
    pad(b, 192);
  endtask
  task automatic cap1(int n, int drop_at, int meddle_at);
    for (int i = 0; i < n; i++) begin
      env_tr[i]  = b1.ir_envelope;
      out_tr[i]  = b1.ir_out;
      done_tr[i] = b1.done;
      if (i == drop_at) b1.repeat_en = 1'b0;
      if (i == meddle_at) begin
        b1.start   = 1'b1;
        b1.address = 8'hFF;
        b1.command = 8'hFF;
      end
      if (i == meddle_at + 1) b1.start = 1'b0;
      tick();
    end
  endtask
  task automatic cmp_env(string tag, int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (env_tr[i] !== exp_env[i]) bad++;
    chk(tag, bad, 0);
  endtask
  task automatic count_done(string tag, int n, int exp);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (done_tr[i] === 1'b1) cnt++;
    chk(tag, cnt, exp);
  endtask
  task automatic low_run(string tag, int start, int exp);
    int len;
    len = 0;
    while (start + len < 2400 && env_tr[start + len] === 1'b0) len++;
    chk(tag, len, exp);
  endtask
  task automatic send1(logic [7:0] a, logic [7:0] c);
    b1.address = a;
    b1.command = c;
    b1.start   = 1'b1;
    tick();
    b1.start   = 1'b0;
  endtask
  initial begin
    int nz, bad;
    b1.start = 1'b1; b1.address = 8'h33; b1.command = 8'h44; b1.repeat_en = 1'b1;
    b2.start = 1'b0; b2.address = 8'h00; b2.command = 8'h00; b2.repeat_en = 1'b0;
    tick(3);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_env", b1.ir_envelope, 0);
    chk("rst_out", b1.ir_out, 0);
    b1.start = 1'b0;
    b1.repeat_en = 1'b0;
    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      if (b1.busy || b1.done || b1.ir_envelope || b1.ir_out) nz++;
      tick();
    end
    chk("idle_quiet", nz, 0);
    send1(8'h5A, 8'h0C);
    chk("t2_busy_n1", b1.busy, 1);
    chk("t2_env_n1", b1.ir_envelope, 1);
    cap1(800, -1, -1);
    build_frame(8'h5A, 8'h0C);
    cmp_env("t2_env_trace", 768);
    chk("t2_lead_end_n64", env_tr[63], 1);
    chk("t2_space_n65", env_tr[64], 0);
    low_run("t2_bit0_space", 100, 4);
    low_run("t2_bit1_space", 108, 12);
    chk("t2_last_mark_n484", env_tr[483], 1);
    chk("t2_after_n485", env_tr[484], 0);
    chk("t2_done_n767", done_tr[766], 0);
    chk("t2_done_n768", done_tr[767], 1);
    count_done("t2_done_count", 800, 1);
    bad = 0;
    for (int i = 0; i < 800; i++) if (out_tr[i] !== env_tr[i]) bad++;
    chk("t2_out_eq_env", bad, 0);
    chk("t2_busy_after", b1.busy, 0);
    b1.repeat_en = 1'b1;
    send1(8'h5A, 8'h0C);
    cap1(2320, 1600, -1);
    build_frame(8'h5A, 8'h0C);
    add_repeat();
    add_repeat();
    cmp_env("t3_env_trace", 2304);
    chk("t3_rep1_mark_start", env_tr[768], 1);
    low_run("t3_rep1_space", 832, 16);
    chk("t3_no_done_n768", done_tr[767], 0);
    chk("t3_no_done_n1536", done_tr[1535], 0);
    chk("t3_done_n2304", done_tr[2303], 1);
    count_done("t3_done_count", 2320, 1);
    chk("t3_busy_after", b1.busy, 0);
    send1(8'h5A, 8'h0C);
    cap1(800, -1, 200);
    build_frame(8'h5A, 8'h0C);
    cmp_env("t4_env_unchanged", 768);
    count_done("t4_done_count", 800, 1);
    tick(50);
    chk("t4_no_second_frame", b1.busy, 0);
    b1.start = 1'b0;
    send1(8'h5A, 8'h0C);
    tick(101);
    chk("t5_busy_before", b1.busy, 1);
    chk("t5_in_space", b1.ir_envelope, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_busy", b1.busy, 0);
    chk("t5_abort_env", b1.ir_envelope, 0);
    chk("t5_abort_done", b1.done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send1(8'hA5, 8'h3C);
    cap1(800, -1, -1);
    build_frame(8'hA5, 8'h3C);
    cmp_env("t5_env_trace", 768);
    chk("t5_done_n768", done_tr[767], 1);
    count_done("t5_done_count", 800, 1);
    b2.address = 8'h5A;
    b2.command = 8'h0C;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      out_tr[i] = b2.ir_out;
      env_tr[i] = b2.ir_envelope;
      tick();
    end
    bad = 0;
    for (int i = 0; i < 128; i++) if (out_tr[i] !== ((i % 4) < 2)) bad++;
    chk("t6_lead_carrier", bad, 0);
    bad = 0;
    for (int i = 128; i < 192; i++) if (out_tr[i] !== 1'b0) bad++;
    chk("t6_lead_space_zero", bad, 0);
    bad = 0;
    for (int i = 192; i < 200; i++) if (out_tr[i] !== ((i % 4) < 2)) bad++;
    chk("t6_bit_mark_carrier", bad, 0);
    chk("t6_bit_mark_env", env_tr[192], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
